cic_rate_ctrl: RTL and testbench
================================

CIC_RATE_CTRL -- requirements
Module: cic_rate_ctrl

Interface
REQ-001 SHALL have parameters: WIDTH, default 16, sample width; RMAX, default 2048, max decimation; N, default 2, CIC order; REG_WIDTH, default WIDTH+N*clog2(RMAX) (=38), CIC output width; RATE_INIT, default RMAX, rate after reset; FLUSH_CYCLES, default 4, CIC reset length.
REQ-002 SHALL have a single clock; reset is synchronous and active-high. Ports (name, direction, width, meaning):
- clk  in  1  sole clock
- rst  in  1  synchronous active-high reset
- cfg_rate  in  clog2(RMAX+1)  requested rate
- cfg_valid  in  1  request valid
- cfg_ready  out  1  request accepted on valid&ready
- src_tvalid  in  1  raw sample valid
- src_tready  out  1  raw sample ready
- cic_rst  out  1  CIC reset
- cic_rate  out  clog2(RMAX+1)  CIC rate
- cic_input_tvalid  out  1  to CIC
- cic_input_tready  in  1  from CIC
- cic_output_tdata  in  REG_WIDTH  CIC result
- cic_output_tvalid  in  1  from CIC
- cic_output_tready  out  1  to CIC
- m_axis_tdata  out  WIDTH  normalised result
- m_axis_tvalid  out  1  result valid
- m_axis_tready  in  1  downstream ready
- busy  out  1  high in FLUSH or SETTLE

Function
REQ-003 SHALL implement states FLUSH, SETTLE, RUN.
REQ-004 FLUSH: cic_rst=1, cic_input_tvalid=0, src_tready=0, cic_output_tready=0, m_axis_tvalid=0, cfg_ready=0; exit to SETTLE after exactly FLUSH_CYCLES clocks.
REQ-005 SETTLE: cic_rst=0, cic_input_tvalid=src_tvalid, src_tready=cic_input_tready, cic_output_tready=1, m_axis_tvalid=0; count CIC output handshakes (discarded); go to RUN after the N-th.
REQ-006 RUN: cic_input_tvalid=src_tvalid, src_tready=cic_input_tready, m_axis_tvalid=cic_output_tvalid, cic_output_tready=m_axis_tready.
REQ-007 cfg_ready SHALL be 1 in SETTLE and 1 in RUN except while m_axis_tvalid=1 and m_axis_tready=0.
REQ-008 On cfg accept: cic_rate loads clamped rate next clock (0 -> 1, >RMAX -> RMAX); state -> FLUSH next clock with flush counter restarted.
REQ-009 Output handshake coincident with cfg accept in RUN SHALL complete; no later beat is forwarded at the old rate.
REQ-010 cfg accept in SETTLE SHALL abort settle and restart FLUSH.
REQ-011 Shift SHALL be registered at accept as N*clog2(clamped rate); m_axis_tdata = low WIDTH bits of arithmetic right shift of cic_output_tdata.
REQ-012 Only rate 0 SHALL be modified by the 0 -> 1 clamp; non-power-of-two rates SHALL be accepted as given, using ceil-log2 shift.

Reset
REQ-013 On rst: state=FLUSH, flush/settle counters=0, cic_rate=RATE_INIT, shift=N*clog2(RATE_INIT), busy=1, cic_rst=1, all other outputs 0.
REQ-014 rst mid-FLUSH or mid-SETTLE SHALL restart FLUSH from count 0; rst overrides a simultaneous cfg accept.

Configuration
REQ-015 With CIC_RATE_CTRL_NORM_EN defined: shift per REQ-011.
REQ-016 Without CIC_RATE_CTRL_NORM_EN: shift fixed at N*clog2(RMAX), with no shift register; all else unchanged.

Structure
REQ-017 Package cic_ctrl_pkg SHALL hold the state enum, the clog2 function and the REG_WIDTH/shift-width constants.
REQ-018 Sub-module cic_ctrl_norm SHALL perform the shift and truncation as combinational logic.

Verification
REQ-019 Release rst, hold cfg_valid=0 -> cic_rst high exactly 4 clocks; the first 2 CIC outputs are discarded; busy=0 after the 2nd; cic_rate=2048.
REQ-020 Request rate 4 in RUN, DC input 1000 -> FLUSH, then after settle m_axis_tdata=1000 (CIC 16000 >>4).
REQ-021 Request cfg_rate=0 -> cic_rate=1, shift=0; request 5000 -> cic_rate=2048, shift=22.
REQ-022 RUN with m_axis_tvalid=1 and m_axis_tready=0 while cfg_valid=1 -> cfg_ready=0 until m_axis_tready=1, then accept in that same cycle.
REQ-023 cfg accept during SETTLE, and a separate rst asserted at FLUSH count 2 -> each restarts a full 4-clock FLUSH.
REQ-024 Build without CIC_RATE_CTRL_NORM_EN at rate 4, DC input 1000 -> m_axis_tdata = 16000>>>22 = 0.

Source files
------------

// File: rtl/cic_ctrl_pkg.sv
// Shared definitions for the CIC rate controller.
//   cic_state_t : controller phases (flush the CIC, discard settling outputs, run)
//   clog2()     : ceil(log2(v)), usable in constant and runtime contexts
//   DEF_*       : default geometry; DEF_REG_WIDTH is the CIC output width
//   SHIFT_W     : width of the normalisation shift amount
package cic_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_FLUSH  = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } cic_state_t;

    // ceil(log2(v)); clog2(1) = 0, clog2(5) = 3.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(v)) r = i + 1;
        end
        return r;
    endfunction

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_RMAX      = 2048;
    localparam int DEF_N         = 2;
    localparam int DEF_REG_WIDTH = DEF_WIDTH + DEF_N * clog2(DEF_RMAX);
    localparam int SHIFT_W       = 8;

endpackage

// File: rtl/cic_ctrl_norm.sv
// Gain normalisation for the CIC output: arithmetic right shift of the full
// CIC word, then keep the low WIDTH bits. Purely combinational.
//   din   : CIC output word (REG_WIDTH, two's complement)
//   shift : right-shift amount
//   dout  : normalised sample (WIDTH)
module cic_ctrl_norm
    import cic_ctrl_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int REG_WIDTH = 38
) (
    input  logic [REG_WIDTH-1:0] din,
    input  logic [SHIFT_W-1:0]   shift,
    output logic [WIDTH-1:0]     dout
);

    // The shift is evaluated at full REG_WIDTH so sign bits reach the low
    // bits for large shifts; the size cast then drops the upper bits.
    assign dout = WIDTH'($signed(din) >>> shift);

endmodule

// File: rtl/cic_rate_ctrl.sv
// Rate controller for a CIC decimator. On a rate change it holds the CIC in
// reset for FLUSH_CYCLES clocks, discards the first N outputs while the
// integrators settle, then forwards normalised samples downstream.
// Optional feature macro: CIC_RATE_CTRL_NORM_EN -- when defined the shift
// tracks N*clog2(rate) of the accepted rate; otherwise it is fixed at
// N*clog2(RMAX).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cfg_rate/cfg_valid/cfg_ready  rate request handshake
//   src_tvalid/src_tready         raw sample handshake (passed to CIC)
//   cic_rst, cic_rate             CIC reset and rate
//   cic_input_tvalid/tready       CIC input handshake
//   cic_output_tdata/tvalid/tready CIC output handshake
//   m_axis_tdata/tvalid/tready    normalised output stream
//   busy                          high while flushing or settling
module cic_rate_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int RMAX         = 2048,
    parameter int N            = 2,
    parameter int REG_WIDTH    = WIDTH + N * clog2(RMAX),
    parameter int RATE_INIT    = RMAX,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [clog2(RMAX+1)-1:0]   cfg_rate,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic                       src_tvalid,
    output logic                       src_tready,
    output logic                       cic_rst,
    output logic [clog2(RMAX+1)-1:0]   cic_rate,
    output logic                       cic_input_tvalid,
    input  logic                       cic_input_tready,
    input  logic [REG_WIDTH-1:0]       cic_output_tdata,
    input  logic                       cic_output_tvalid,
    output logic                       cic_output_tready,
    output logic [WIDTH-1:0]           m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       busy
);

    localparam int RATE_W = clog2(RMAX + 1);
    localparam int FCNT_W = clog2(FLUSH_CYCLES + 1);
    localparam int SCNT_W = clog2(N + 1);

    cic_state_t          state, state_nxt;
    logic [FCNT_W-1:0]   flush_cnt, flush_cnt_nxt;
    logic [SCNT_W-1:0]   settle_cnt, settle_cnt_nxt;
    logic [RATE_W-1:0]   rate_q, rate_clamped;
    logic [SHIFT_W-1:0]  shift;
    logic                cfg_acc;

    // Only 0 is bumped up; anything above RMAX saturates.
    always_comb begin
        rate_clamped = cfg_rate;
        if (cfg_rate == '0)
            rate_clamped = RATE_W'(1);
        else if (cfg_rate > RATE_W'(RMAX))
            rate_clamped = RATE_W'(RMAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FLUSH;
            flush_cnt  <= '0;
            settle_cnt <= '0;
            rate_q     <= RATE_W'(RATE_INIT);
        end else begin
            state      <= state_nxt;
            flush_cnt  <= flush_cnt_nxt;
            settle_cnt <= settle_cnt_nxt;
            if (cfg_acc) rate_q <= rate_clamped;
        end
    end

    always_comb begin
        state_nxt         = state;
        flush_cnt_nxt     = flush_cnt;
        settle_cnt_nxt    = settle_cnt;
        cic_rst           = 1'b0;
        cic_input_tvalid  = 1'b0;
        src_tready        = 1'b0;
        cic_output_tready = 1'b0;
        m_axis_tvalid     = 1'b0;
        cfg_ready         = 1'b0;
        busy              = 1'b0;
        cfg_acc           = 1'b0;

        case (state)
            ST_FLUSH: begin
                cic_rst = 1'b1;
                busy    = 1'b1;
                if (flush_cnt == FCNT_W'(FLUSH_CYCLES - 1)) begin
                    state_nxt      = ST_SETTLE;
                    flush_cnt_nxt  = '0;
                    settle_cnt_nxt = '0;
                end else begin
                    flush_cnt_nxt = flush_cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                // Outputs are drained and dropped while the integrators settle.
                cic_input_tvalid  = src_tvalid;
                src_tready        = cic_input_tready;
                cic_output_tready = 1'b1;
                cfg_ready         = 1'b1;
                busy              = 1'b1;
                if (cic_output_tvalid) begin
                    if (settle_cnt == SCNT_W'(N - 1)) begin
                        state_nxt      = ST_RUN;
                        settle_cnt_nxt = '0;
                    end else begin
                        settle_cnt_nxt = settle_cnt + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cic_input_tvalid  = src_tvalid;
                src_tready        = cic_input_tready;
                m_axis_tvalid     = cic_output_tvalid;
                cic_output_tready = m_axis_tready;
                // Hold off a rate change while a beat is stalled downstream, so
                // the pending beat is never stranded at the old rate.
                cfg_ready         = !(cic_output_tvalid && !m_axis_tready);
            end
            default: state_nxt = ST_FLUSH;
        endcase

        cfg_acc = cfg_valid && cfg_ready;
        if (cfg_acc) begin
            state_nxt      = ST_FLUSH;
            flush_cnt_nxt  = '0;
            settle_cnt_nxt = '0;
        end
    end

`ifdef CIC_RATE_CTRL_NORM_EN
    logic [SHIFT_W-1:0] shift_q;

    always_ff @(posedge clk) begin
        if (rst)
            shift_q <= SHIFT_W'(N * clog2(RATE_INIT));
        else if (cfg_acc)
            shift_q <= SHIFT_W'(N * clog2(int'(rate_clamped)));
    end

    assign shift = shift_q;
`else
    assign shift = SHIFT_W'(N * clog2(RMAX));
`endif

    assign cic_rate = rate_q;

    cic_ctrl_norm #(
        .WIDTH     (WIDTH),
        .REG_WIDTH (REG_WIDTH)
    ) u_norm (
        .din   (cic_output_tdata),
        .shift (shift),
        .dout  (m_axis_tdata)
    );

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Self-checking bench for cic_rate_ctrl: a behavioural model checks every
// output each cycle, plus a rate table and hand-written corner sequences.
module tb_cic_rate_ctrl;

    localparam int WIDTH = 16;
    localparam int RMAX  = 2048;
    localparam int N     = 2;
    localparam int REG_W = 38;
    localparam int FLUSH = 4;
`ifdef CIC_RATE_CTRL_NORM_EN
    localparam bit NORM = 1'b1;
`else
    localparam bit NORM = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [11:0]       cfg_rate = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic              src_tvalid = 1'b0;
    logic              src_tready;
    logic              cic_rst;
    logic [11:0]       cic_rate;
    logic              cic_input_tvalid;
    logic              cic_input_tready = 1'b0;
    logic [REG_W-1:0]  cic_output_tdata = '0;
    logic              cic_output_tvalid = 1'b0;
    logic              cic_output_tready;
    logic [WIDTH-1:0]  m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic              busy;

    cic_rate_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_rate          (cfg_rate),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .src_tvalid        (src_tvalid),
        .src_tready        (src_tready),
        .cic_rst           (cic_rst),
        .cic_rate          (cic_rate),
        .cic_input_tvalid  (cic_input_tvalid),
        .cic_input_tready  (cic_input_tready),
        .cic_output_tdata  (cic_output_tdata),
        .cic_output_tvalid (cic_output_tvalid),
        .cic_output_tready (cic_output_tready),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d @%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // flush_left: remaining reset clocks; settle_left: outputs still to drop.
    int m_flush  = FLUSH;
    int m_settle = N;
    int m_rate   = RMAX;
    int m_shift  = N * $clog2(RMAX);
    bit chk_en   = 1'b0;

    function automatic int clamp(input int r);
        if (r == 0) return 1;
        if (r > RMAX) return RMAX;
        return r;
    endfunction

    function automatic int shift_of(input int r);
        return NORM ? N * $clog2(r) : N * $clog2(RMAX);
    endfunction

    // floor(d / 2^s), low 16 bits
    function automatic logic [15:0] norm(input logic [REG_W-1:0] d, input int s);
        longint v, p, q;
        v = longint'($signed(d));
        p = longint'(1) << s;
        q = v / p;
        if (v < 0 && q * p != v) q = q - 1;
        return q[15:0];
    endfunction

    function automatic bit exp_cfg_ready();
        if (m_flush > 0) return 1'b0;
        if (m_settle > 0) return 1'b1;
        return !(cic_output_tvalid && !m_axis_tready);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_flush = FLUSH; m_settle = N; m_rate = RMAX; m_shift = shift_of(RMAX);
        end else if (cfg_valid && exp_cfg_ready()) begin
            m_flush = FLUSH; m_settle = N; m_rate = clamp(int'(cfg_rate)); m_shift = shift_of(m_rate);
        end else if (m_flush > 0) begin
            m_flush = m_flush - 1;
        end else if (m_settle > 0 && cic_output_tvalid) begin
            m_settle = m_settle - 1;
        end
    end

    always @(negedge clk) begin
        bit fl, st, rn;
        if (chk_en) begin
            fl = (m_flush > 0);
            st = !fl && (m_settle > 0);
            rn = !fl && !st;
            chk("cic_rst", cic_rst, fl);
            chk("busy", busy, !rn);
            chk("cfg_ready", cfg_ready, exp_cfg_ready());
            chk("cic_in_vld", cic_input_tvalid, fl ? 1'b0 : src_tvalid);
            chk("src_rdy", src_tready, fl ? 1'b0 : cic_input_tready);
            chk("cic_out_rdy", cic_output_tready, fl ? 1'b0 : (st ? 1'b1 : m_axis_tready));
            chk("m_vld", m_axis_tvalid, rn ? cic_output_tvalid : 1'b0);
            chk("cic_rate", cic_rate, m_rate);
            if (rn && cic_output_tvalid)
                chk("m_data", m_axis_tdata, norm(cic_output_tdata, m_shift));
        end
    end

    // ---------------- helpers ----------------
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // Counts consecutive cic_rst-high cycles starting with the current one.
    task automatic flush_len(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!cic_rst) break;
            n++;
            nxt();
        end
    endtask

    // Caller holds cic_output_tvalid high so settle completes.
    task automatic wait_run();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
            nxt();
        end
        chk("wait_run", ok, 1'b1);
    endtask

    // Issue a rate request from RUN (called at a negedge); ends at the
    // negedge of the first flush cycle.
    task automatic req(input int rate);
        nxt();
        cic_output_tvalid = 1'b0;
        cfg_valid = 1'b1;
        cfg_rate  = 12'(rate);
        @(negedge clk);
        chk("req_cfg_rdy", cfg_ready, 1'b1);
        nxt();
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("req_flush", cic_rst, 1'b1);
    endtask

    typedef struct {
        int rate;
        int exp_rate;
        int exp_shift;
    } vec_t;

    vec_t tbl[9];
    logic [REG_W-1:0] tv;
    int n;

    initial begin
        tbl[0] = '{0, 1, 0};
        tbl[1] = '{1, 1, 0};
        tbl[2] = '{4, 4, 4};
        tbl[3] = '{5, 5, 6};
        tbl[4] = '{3, 3, 4};
        tbl[5] = '{1000, 1000, 20};
        tbl[6] = '{2048, 2048, 22};
        tbl[7] = '{2049, 2048, 22};
        tbl[8] = '{4095, 2048, 22};
        tv = 38'h3A_5C3E_9172;

        // reset state
        nxt();
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_cic_rst", cic_rst, 1'b1);
        chk("rst_busy", busy, 1'b1);
        chk("rst_rate", cic_rate, 2048);
        chk("rst_cfg_rdy", cfg_ready, 1'b0);
        chk("rst_outs", {src_tready, cic_input_tvalid, cic_output_tready, m_axis_tvalid, m_axis_tdata}, 0);
        nxt();
        rst = 1'b0;

        // startup: 4 flush clocks, 2 discarded outputs
        flush_len(n);
        chk("startup_flush_len", n, FLUSH);
        nxt();
        cic_output_tvalid = 1'b1;
        cic_output_tdata  = 38'd12345;
        m_axis_tready     = 1'b1;
        @(negedge clk);
        chk("settle_beat1_busy", busy, 1'b1);
        nxt();
        @(negedge clk);
        chk("settle_beat2_busy", busy, 1'b1);
        chk("settle_beat2_mvld", m_axis_tvalid, 1'b0);
        nxt();
        @(negedge clk);
        chk("run_busy", busy, 1'b0);
        chk("run_mvld", m_axis_tvalid, 1'b1);
        chk("run_rate", cic_rate, 2048);

        // DC 1000 at rate 4: CIC output 16000
        req(4);
        nxt();
        cic_output_tvalid = 1'b1;
        cic_output_tdata  = 38'd16000;
        wait_run();
        chk("dc1000", m_axis_tdata, NORM ? 1000 : 0);

        // rate table: clamp and shift
        for (int i = 0; i < 9; i++) begin
            req(tbl[i].rate);
            chk("tbl_rate", cic_rate, tbl[i].exp_rate);
            nxt();
            cic_output_tvalid = 1'b1;
            cic_output_tdata  = tv;
            wait_run();
            chk("tbl_data", m_axis_tdata, norm(tv, NORM ? tbl[i].exp_shift : 22));
        end

        // downstream stall blocks cfg until ready, then accepts same cycle
        nxt();
        cic_output_tvalid = 1'b1;
        m_axis_tready = 1'b0;
        cfg_valid = 1'b1;
        cfg_rate  = 12'd8;
        @(negedge clk);
        chk("stall_rdy0", cfg_ready, 1'b0);
        nxt();
        @(negedge clk);
        chk("stall_rdy1", cfg_ready, 1'b0);
        chk("stall_no_acc", busy, 1'b0);
        nxt();
        m_axis_tready = 1'b1;
        @(negedge clk);
        chk("stall_release", cfg_ready, 1'b1);
        chk("stall_beat", m_axis_tvalid, 1'b1);
        nxt();
        cfg_valid = 1'b0;
        cic_output_tvalid = 1'b0;
        @(negedge clk);
        chk("stall_acc", cic_rst, 1'b1);
        chk("stall_rate", cic_rate, 8);

        // cfg accept in SETTLE restarts a full flush
        for (int i = 0; i < 20; i++) begin
            nxt();
            @(negedge clk);
            if (!cic_rst) break;
        end
        nxt();
        cic_output_tvalid = 1'b1;
        @(negedge clk);
        chk("settle_one_beat", busy, 1'b1);
        nxt();
        cic_output_tvalid = 1'b0;
        cfg_valid = 1'b1;
        cfg_rate  = 12'd32;
        @(negedge clk);
        chk("settle_cfg_rdy", cfg_ready, 1'b1);
        nxt();
        cfg_valid = 1'b0;
        flush_len(n);
        chk("settle_abort_flush", n, FLUSH);
        chk("settle_abort_rate", cic_rate, 32);

        // rst at flush count 2 restarts from 0
        req(64);
        nxt();
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        flush_len(n);
        chk("rst_mid_flush", n, FLUSH);
        chk("rst_mid_rate", cic_rate, 2048);

        // rst beats a simultaneous cfg accept in RUN
        nxt();
        cic_output_tvalid = 1'b1;
        wait_run();
        nxt();
        cic_output_tvalid = 1'b0;
        cfg_valid = 1'b1;
        cfg_rate  = 12'd4;
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("rst_over_cfg_rate", cic_rate, 2048);
        chk("rst_over_cfg_flush", cic_rst, 1'b1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            nxt();
            rst               = ($urandom_range(299) == 0);
            cfg_valid         = ($urandom_range(29) == 0);
            case ($urandom_range(3))
                0: cfg_rate = 12'd0;
                1: cfg_rate = 12'($urandom);
                default: cfg_rate = 12'($urandom_range(64, 1));
            endcase
            src_tvalid        = $urandom_range(1) == 1;
            cic_input_tready  = $urandom_range(1) == 1;
            cic_output_tvalid = $urandom_range(1) == 1;
            m_axis_tready     = $urandom_range(3) != 0;
            cic_output_tdata  = REG_W'({$urandom, $urandom});
        end

        nxt();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
